// File: rtl/uart_rx_mmio_pkg.sv
// ============================================================================
// Module      : uart_rx_mmio_pkg
// Description : Shared definitions for the memory-mapped UART receiver:
//               register offsets, STATUS bit positions, receiver FSM states
//               and the STATUS byte packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_mmio_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [15:0] OFF_DATA   = 16'd0;
  localparam logic [15:0] OFF_STATUS = 16'd1;

  // STATUS register bit positions
  localparam int STAT_AVAIL = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_FERR  = 3;
  localparam int STAT_PERR  = 4;

  // Receiver states; PARITY is only reachable when parity checking is built in
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic [7:0] pack_status(input logic perr, input logic ferr,
                                             input logic ovr, input logic full,
                                             input logic avail);
    logic [7:0] s;
    s             = 8'h00;
    s[STAT_PERR]  = perr;
    s[STAT_FERR]  = ferr;
    s[STAT_OVR]   = ovr;
    s[STAT_FULL]  = full;
    s[STAT_AVAIL] = avail;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_mmio_if.sv
// ============================================================================
// Module      : uart_rx_mmio_if
// Description : CPU-side control signals of the UART receiver peripheral.
//               The CPU (master) drives address and strobes; the peripheral
//               (slave) reports data availability.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_mmio_if;
  logic [15:0] addr;
  logic        ce;
  logic        r;
  logic        oe;
  logic        rx_avail;

  modport master (output addr, output ce, output r, output oe, input rx_avail);
  modport slave  (input addr, input ce, input r, input oe, output rx_avail);
endinterface

`default_nettype wire

// File: rtl/uart_rx_mmio_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous byte FIFO. A pop in the same cycle as a push is
//               applied first, so a push into a full FIFO that is being
//               popped is accepted. A push into a full FIFO otherwise is
//               dropped and reported on ovr_o for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       push_i,
  input  wire logic [7:0] din_i,
  input  wire logic       pop_i,
  output logic      [7:0] head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            ovr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop, do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign ovr_o   = push_i && !do_push;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_mmio.sv
// ============================================================================
// Module      : uart_rx_mmio
// Description : Memory-mapped UART receiver (8N1) with an RX FIFO. DATA at
//               BASE_ADDR pops one byte per read access, STATUS at
//               BASE_ADDR+1 reports {PERR,FERR,OVR,full,avail} and clears the
//               sticky error flags after the first cycle of the access.
//               Optional macro UART_RX_PARITY_EN selects 8E1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int          CLK_HZ     = 27_000_000,
  parameter int          BAUD       = 9600,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BASE_ADDR  = 16'hFF02
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       rx,
  uart_rx_mmio_if.slave   bus,
  // Tri-state read data kept as a plain port so the driver sits on the boundary
  output wire logic [7:0] out_data
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_meta_q, rx_sync_q;
  logic             ovr_q, ferr_q, perr_q;
  logic             data_acc_q, stat_acc_q;
  logic             push, ferr_set, perr_set, fifo_ovr;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
`endif

  // Two-flop synchronizer for the asynchronous serial line (idles high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver state register, baud counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state logic: every bit is sampled when the counter reaches zero
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    perr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          state_d = ST_START;
          cnt_d   = CNT_HALF;
        end
      end
      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_sync_q) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          cnt_d     = CNT_FULL;
        end else begin
          state_d = ST_IDLE;       // line went back high: glitch, not a frame
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          par_bad_d = (^shift_q) ^ rx_sync_q;   // even parity over data + parity bit
          cnt_d     = CNT_FULL;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d  = ST_IDLE;
          ferr_set = !rx_sync_q;
`ifdef UART_RX_PARITY_EN
          perr_set = par_bad_q;
          push     = rx_sync_q && !par_bad_q;
`else
          push     = rx_sync_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address decode and access-edge detection
  logic hit_data, hit_stat, rd_acc, data_acc, pop, stat_first, drive;
  assign hit_data   = (bus.addr == BASE_ADDR + OFF_DATA);
  assign hit_stat   = (bus.addr == BASE_ADDR + OFF_STATUS);
  assign rd_acc     = bus.ce && bus.r;
  assign data_acc   = rd_acc && hit_data;
  assign pop        = data_acc && !data_acc_q;
  assign stat_first = rd_acc && hit_stat && !stat_acc_q;
  assign drive      = rd_acc && bus.oe && (hit_data || hit_stat);

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (shift_q),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .ovr_o   (fifo_ovr)
  );

  // Sticky error flags; a new error in the clearing cycle is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      data_acc_q <= 1'b0;
      stat_acc_q <= 1'b0;
    end else begin
      ovr_q      <= fifo_ovr || (ovr_q && !stat_first);
      ferr_q     <= ferr_set || (ferr_q && !stat_first);
      perr_q     <= perr_set || (perr_q && !stat_first);
      data_acc_q <= data_acc;
      stat_acc_q <= rd_acc && hit_stat;
    end
  end

  logic [7:0] rd_val;
  assign rd_val = hit_stat ? pack_status(perr_q, ferr_q, ovr_q, fifo_full, !fifo_empty)
                           : (fifo_empty ? 8'h00 : fifo_head);

  assign out_data     = drive ? rd_val : 8'bz;
  assign bus.rx_avail = !fifo_empty;

endmodule

`default_nettype wire
